// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle controller and the RV32I datapath.
//   Instruction fields and the ALU zero flag go to the controller.
//   Mux selects, write enables and the ALU operation code come back.
//   master: controller side (reads fields and zero, drives the controls)
//   slave : datapath side (drives fields and zero, reads the controls)
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] ALU_srcA;
    logic [1:0] ALU_srcB;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [2:0] ALU_control;
    logic       illegal_op;

    modport master (
        input  opcode, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               ALU_srcA, ALU_srcB, imm_src, reg_write, ALU_control, illegal_op
    );

    modport slave (
        output opcode, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               ALU_srcA, ALU_srcB, imm_src, reg_write, ALU_control, illegal_op
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control unit for the multicycle RV32I core.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, state returns to FETCH
//   bus   : multicycle_controller_if.master
//           in  opcode/funct3/funct7b5 from the instruction register, zero from the ALU
//           out mux selects, write enables, ALU_control, imm_src, illegal_op
// All outputs are combinational from the state and the instruction fields.
module multicycle_controller (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_controller_if.master  bus
);
    localparam int unsigned OP_W  = 7;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    state_e     state_q, state_d;

    logic       pc_update_c, branch_c;
    logic [1:0] alu_op_c;
    logic       adr_src_c, mem_write_c, ir_write_c, reg_write_c, illegal_c;
    logic [1:0] result_src_c, src_a_c, src_b_c, imm_src_c;
    logic [2:0] alu_control_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state Moore outputs; unreachable encodings leave everything at 0
    always_comb begin
        pc_update_c  = 1'b0;
        branch_c     = 1'b0;
        alu_op_c     = 2'b00;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;
        result_src_c = 2'b00;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_c   = 1'b1;
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
                pc_update_c  = 1'b1;
            end
            S_DECODE: begin
                src_a_c = 2'b01;
                src_b_c = 2'b01;
                illegal_c = !(bus.opcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ});
            end
            S_MEMADR: begin
                src_a_c = 2'b10;
                src_b_c = 2'b01;
            end
            S_MEMREAD: adr_src_c = 1'b1;
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECR: begin
                src_a_c  = 2'b10;
                alu_op_c = 2'b10;
            end
            S_EXECI: begin
                src_a_c  = 2'b10;
                src_b_c  = 2'b01;
                alu_op_c = 2'b10;
            end
            S_JAL: begin
                src_a_c     = 2'b01;
                src_b_c     = 2'b10;
                pc_update_c = 1'b1;
            end
            S_ALUWB: reg_write_c = 1'b1;
            S_BEQ: begin
                src_a_c  = 2'b10;
                alu_op_c = 2'b01;
                branch_c = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU operation decode; SUB vs ADD for funct3=000 only applies to R-type
    always_comb begin
        alu_control_c = ALU_ADD;
        case (alu_op_c)
            2'b01: alu_control_c = ALU_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_control_c = (bus.opcode[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_c = ALU_SLT;
                    3'b110:  alu_control_c = ALU_OR;
                    3'b111:  alu_control_c = ALU_AND;
                    default: alu_control_c = ALU_ADD;
                endcase
            end
            default: alu_control_c = ALU_ADD;
        endcase
    end

    // Immediate format depends only on the opcode
    always_comb begin
        imm_src_c = 2'b00;
        case (bus.opcode)
            OP_SW:   imm_src_c = 2'b01;
            OP_BEQ:  imm_src_c = 2'b10;
            OP_JAL:  imm_src_c = 2'b11;
            default: imm_src_c = 2'b00;
        endcase
    end

    // Enables are gated by reset so an in-flight write drops as soon as reset rises
    assign bus.pc_write    = (pc_update_c | (branch_c & bus.zero)) & ~reset;
    assign bus.ir_write    = ir_write_c  & ~reset;
    assign bus.reg_write   = reg_write_c & ~reset;
    assign bus.mem_write   = mem_write_c & ~reset;
    assign bus.illegal_op  = illegal_c   & ~reset;
    assign bus.adr_src     = adr_src_c;
    assign bus.result_src  = result_src_c;
    assign bus.ALU_srcA    = src_a_c;
    assign bus.ALU_srcB    = src_b_c;
    assign bus.imm_src     = imm_src_c;
    assign bus.ALU_control = alu_control_c;
endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
    logic clk;
    logic reset;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // {pc_write, adr_src, mem_write, ir_write, result_src, srcA, srcB, imm_src, reg_write, ALU_control, illegal_op}
    function automatic logic [16:0] e(input logic pw, input logic adr, input logic mw, input logic ir,
                                      input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] imm, input logic rw, input logic [2:0] alu,
                                      input logic ill);
        return {pw, adr, mw, ir, rs, a, b, imm, rw, alu, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.ALU_srcA, bus.ALU_srcB, bus.imm_src, bus.reg_write, bus.ALU_control,
                bus.illegal_op};
    endfunction

    task automatic add(input string n, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [16:0] x);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [16:0] x);
        logic [16:0] got;
        got = observed();
        checks++;
        if (got !== x) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b", n, got, x);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.zero     = z;
    endtask

    initial begin
        // lw: FETCH DECODE MEMADR MEMREAD MEMWB
        add("lw_fetch",   7'b0000011, 3'b010, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        add("lw_decode",  7'b0000011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b010,0));
        add("lw_memadr",  7'b0000011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b010,0));
        add("lw_memread", 7'b0000011, 3'b010, 1'b0, 1'b0, e(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,3'b010,0));
        add("lw_memwb",   7'b0000011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,3'b010,0));
        // sw: FETCH DECODE MEMADR MEMWRITE
        add("sw_fetch",   7'b0100011, 3'b010, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,3'b010,0));
        add("sw_decode",  7'b0100011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b01,0,3'b010,0));
        add("sw_memadr",  7'b0100011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b010,0));
        add("sw_memwr",   7'b0100011, 3'b010, 1'b0, 1'b0, e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b010,0));
        // R sub
        add("sub_fetch",  7'b0110011, 3'b000, 1'b1, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        add("sub_decode", 7'b0110011, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b010,0));
        add("sub_execr",  7'b0110011, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b110,0));
        add("sub_aluwb",  7'b0110011, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b010,0));
        // addi with funct7b5=1 must still add
        add("addi_fetch", 7'b0010011, 3'b000, 1'b1, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        add("addi_decode",7'b0010011, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b010,0));
        add("addi_execi", 7'b0010011, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b010,0));
        add("addi_aluwb", 7'b0010011, 3'b000, 1'b1, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b010,0));
        // R and / slt
        add("and_fetch",  7'b0110011, 3'b111, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        add("and_decode", 7'b0110011, 3'b111, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b010,0));
        add("and_execr",  7'b0110011, 3'b111, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b000,0));
        add("and_aluwb",  7'b0110011, 3'b111, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b010,0));
        add("slt_fetch",  7'b0110011, 3'b010, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        add("slt_decode", 7'b0110011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b010,0));
        add("slt_execr",  7'b0110011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b111,0));
        add("slt_aluwb",  7'b0110011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b010,0));
        // ori
        add("ori_fetch",  7'b0010011, 3'b110, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        add("ori_decode", 7'b0010011, 3'b110, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b010,0));
        add("ori_execi",  7'b0010011, 3'b110, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,3'b001,0));
        add("ori_aluwb",  7'b0010011, 3'b110, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b010,0));
        // beq taken (zero held high; DECODE must not write PC)
        add("beqT_fetch", 7'b1100011, 3'b000, 1'b0, 1'b1, e(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,3'b010,0));
        add("beqT_decode",7'b1100011, 3'b000, 1'b0, 1'b1, e(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,3'b010,0));
        add("beqT_beq",   7'b1100011, 3'b000, 1'b0, 1'b1, e(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b110,0));
        // beq not taken
        add("beqN_fetch", 7'b1100011, 3'b000, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,3'b010,0));
        add("beqN_decode",7'b1100011, 3'b000, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,3'b010,0));
        add("beqN_beq",   7'b1100011, 3'b000, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b110,0));
        // jal
        add("jal_fetch",  7'b1101111, 3'b000, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b11,0,3'b010,0));
        add("jal_decode", 7'b1101111, 3'b000, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b11,0,3'b010,0));
        add("jal_jal",    7'b1101111, 3'b000, 1'b0, 1'b0, e(1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,3'b010,0));
        add("jal_aluwb",  7'b1101111, 3'b000, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b00,2'b00,2'b11,1,3'b010,0));
        // illegal opcode
        add("ill_fetch",  7'b1111111, 3'b000, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        add("ill_decode", 7'b1111111, 3'b000, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b010,1));
        add("ill_refetch",7'b1111111, 3'b000, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        add("ill_decode2",7'b1111111, 3'b000, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b010,1));
        add("sw2_fetch",  7'b0100011, 3'b010, 1'b0, 1'b0, e(1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,3'b010,0));
        add("sw2_decode", 7'b0100011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b01,2'b01,2'b01,0,3'b010,0));
        add("sw2_memadr", 7'b0100011, 3'b010, 1'b0, 1'b0, e(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b010,0));
        add("sw2_memwr",  7'b0100011, 3'b010, 1'b0, 1'b0, e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b010,0));

        // Reset for two cycles: enables low, selects at FETCH values
        reset = 1'b1;
        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_c1", e(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        @(negedge clk);
        check("reset_c2", e(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b010,0));
        reset = 1'b0;

        // One vector per clock, checked in the low phase
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
            #1;
            check(vecs[i].name, vecs[i].exp);
            @(negedge clk);
        end

        // Now in the FETCH after sw2's MEMWRITE; redo sw and hit reset inside MEMWRITE
        drive(7'b0100011, 3'b010, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("mw_before_reset", e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b010,0));
        #1 reset = 1'b1;
        #1;
        check("mw_reset_async", e(0,0,0,0,2'b10,2'b00,2'b10,2'b01,0,3'b010,0));
        @(negedge clk);
        check("mw_reset_hold", e(0,0,0,0,2'b10,2'b00,2'b10,2'b01,0,3'b010,0));
        reset = 1'b0;
        #1;
        check("post_reset_fetch", e(1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,3'b010,0));
        @(negedge clk);
        check("post_reset_decode", e(0,0,0,0,2'b00,2'b01,2'b01,2'b01,0,3'b010,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
